// File: rtl/fpaddsub_normalize_sequencer.sv
// rtl/fpaddsub_normalize_sequencer.sv - multi-cycle leading-zero normalizer with one shared shifter
module fpaddsub_normalize_sequencer #(
    parameter int MW = 26,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InValid,
    output logic          InReady,
    input  logic [MW-1:0] Sum,
    input  logic [EW-1:0] Exp,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [MW-1:0] Mout,
    output logic [EW-1:0] Eout,
    output logic          Zero,
    output logic          Underflow,
    output logic [4:0]    Shift
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [4:0]    lz;

    // Leading-zero count of the incoming sum; the highest set bit wins, all-zero gives MW.
    always_comb begin
        lz = 5'(MW);
        for (int i = 0; i < MW; i++) begin
            if (Sum[i]) begin
                lz = 5'(MW - 1 - i);
            end
        end
    end

    // Ready only when idle; held low during reset so nothing is accepted on the reset edge.
    assign InReady = (state == IDLE) && !rst;

    assign Mout = m;
    assign Eout = e;

    // Sequencer: latch job, coarse shift by multiples of 4, fine shift plus exponent adjust, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m         <= '0;
            e         <= '0;
            Shift     <= '0;
            Zero      <= 1'b0;
            Underflow <= 1'b0;
            OutValid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        Shift     <= lz;
                        Underflow <= 1'b0;
                        if (Sum == '0) begin
                            m        <= '0;
                            e        <= '0;
                            Zero     <= 1'b1;
                            OutValid <= 1'b1;
                            state    <= DONE;
                        end else begin
                            m     <= Sum;
                            e     <= Exp;
                            Zero  <= 1'b0;
                            state <= COARSE;
                        end
                    end
                end
                COARSE: begin
                    m     <= m << {Shift[4:2], 2'b00};
                    state <= FINE;
                end
                FINE: begin
                    m <= m << Shift[1:0];
                    // Compare guards the subtraction so the unsigned exponent never wraps.
                    if (e > EW'(Shift)) begin
                        e         <= e - EW'(Shift);
                        Underflow <= 1'b0;
                    end else begin
                        e         <= '0;
                        Underflow <= 1'b1;
                    end
                    OutValid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpaddsub_normalize_sequencer.sv
// tb/tb_fpaddsub_normalize_sequencer.sv - scoreboard bench with randomized jobs and a reference normalizer
module tb_fpaddsub_normalize_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [25:0] Sum = '0;
    logic [7:0]  Exp = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [25:0] Mout;
    logic [7:0]  Eout;
    logic        Zero;
    logic        Underflow;
    logic [4:0]  Shift;

    fpaddsub_normalize_sequencer #(.MW(26), .EW(8)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .Sum(Sum), .Exp(Exp), .OutValid(OutValid), .OutReady(OutReady),
        .Mout(Mout), .Eout(Eout), .Zero(Zero), .Underflow(Underflow), .Shift(Shift)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] m;
        logic [7:0]  e;
        logic        z;
        logic        u;
        logic [4:0]  s;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cmp_count = 0;
    int   err_count = 0;
    int   cyc = 0;
    int   last_pop = -100;
    bit   seen = 1'b0;
    int   rdy_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // OutReady source: 0 = held low, 1 = held high, 2 = random stalls
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: OutReady = 1'b0;
            1: OutReady = 1'b1;
            default: OutReady = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic chk(input string name, input longint act, input longint req);
        cmp_count++;
        if (act != req) begin
            err_count++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: count leading zeros, scale by 2**lz, then apply the exponent rules.
    function automatic exp_t model(input logic [25:0] s, input logic [7:0] ex);
        exp_t   r;
        int     lz;
        longint v;
        lz = 26;
        for (int i = 0; i < 26; i++) begin
            if (s[25 - i] && lz == 26) lz = i;
        end
        r.s = 5'(lz);
        r.u = 1'b0;
        r.z = (lz == 26);
        if (r.z) begin
            r.m   = '0;
            r.e   = '0;
            r.lat = 0;
        end else begin
            v     = longint'(s) * (longint'(1) << lz);
            r.m   = v[25:0];
            r.lat = 2;
            if (int'(ex) > lz) r.e = 8'(int'(ex) - lz);
            else begin
                r.e = '0;
                r.u = 1'b1;
            end
        end
        r.acc = 0;
        return r;
    endfunction

    task automatic send(input logic [25:0] s, input logic [7:0] e, input bit after_pop);
        exp_t x;
        bit   got;
        got = 1'b0;
        InValid = 1'b1;
        Sum = s;
        Exp = e;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (InReady) got = 1'b1;
        end
        if (!got) begin
            err_count++;
            cmp_count++;
            $display("FAIL accept_timeout: InReady never rose for Sum=%h", s);
            InValid = 1'b0;
            return;
        end
        x = model(s, e);
        x.acc = cyc + 1;
        sb.push_back(x);
        if (after_pop) chk("accept_after_pop", x.acc, last_pop + 1);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        Sum = 26'($urandom);
        Exp = 8'($urandom);
    endtask

    // Monitor: compare every presented result with the scoreboard head until it is taken.
    always @(negedge clk) begin
        exp_t h;
        if (rst) begin
            seen = 1'b0;
        end else if (OutValid) begin
            if (sb.size() == 0) begin
                cmp_count++;
                err_count++;
                $display("FAIL unexpected_valid: Mout=%h Eout=%0d with empty scoreboard", Mout, Eout);
            end else begin
                h = sb[0];
                if (!seen) begin
                    chk("latency", cyc - h.acc, h.lat);
                    seen = 1'b1;
                end
                chk("mout", Mout, h.m);
                chk("eout", Eout, h.e);
                chk("zero", Zero, h.z);
                chk("underflow", Underflow, h.u);
                chk("shift", Shift, h.s);
                chk("inready_busy", InReady, 0);
                if (OutReady) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                    last_pop = cyc + 1;
                end
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 1000 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            cmp_count++;
            err_count++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_outvalid"}, OutValid, 0);
        chk({tag, "_inready"}, InReady, 0);
        chk({tag, "_mout"}, Mout, 0);
        chk({tag, "_eout"}, Eout, 0);
        chk({tag, "_zero"}, Zero, 0);
        chk({tag, "_underflow"}, Underflow, 0);
        chk({tag, "_shift"}, Shift, 0);
    endtask

    initial begin
        logic [25:0] rs;
        logic [7:0]  re;
        int          sh;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        // Directed cases
        send(26'h2000000, 8'd100, 1'b0);
        send(26'h0000001, 8'd127, 1'b0);
        send(26'h0040000, 8'd5, 1'b0);
        send(26'h0040000, 8'd7, 1'b0);
        send(26'h0040000, 8'd8, 1'b0);
        send(26'h0000000, 8'd50, 1'b0);
        send(26'h0000000, 8'd3, 1'b0);
        send(26'h1234567, 8'd0, 1'b0);
        drain();

        // Back-pressure: result held with a new job waiting on the inputs
        rdy_mode = 0;
        send(26'h0008000, 8'd40, 1'b0);
        fork
            begin
                repeat (13) @(posedge clk);
                rdy_mode = 1;
            end
        join_none
        send(26'h0300000, 8'd20, 1'b1);
        drain();

        // Reset while the job is in FINE
        send(26'h0000400, 8'd60, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("midjob_reset");
        sb.delete();
        rst = 1'b0;
        send(26'h0000400, 8'd60, 1'b0);
        drain();

        // Randomized jobs with random downstream stalls
        rdy_mode = 2;
        for (int n = 0; n < 60; n++) begin
            sh = $urandom_range(0, 26);
            rs = (26'h2000000 | 26'($urandom)) >> sh;
            re = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            send(rs, re, 1'b0);
        end
        rdy_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normalize_sequencer.md
# fpaddsub_normalize_sequencer

Multi-cycle normalization controller for the simplified FP add/sub path. It accepts one unnormalized 26-bit sum mantissa and its exponent through a valid/ready handshake and computes the leading-zero count. It then sequences a coarse shift (multiples of 4) followed by a fine shift (0–3 bits) through one internal shift register, and returns the normalized mantissa, adjusted exponent and zero/underflow flags. It sits between the significand adder and the rounding stage. It trades the fully pipelined two-level shifter for a single shared shifter at one result per 4 cycles.

## Interface
Parameters:
- MW, 26, mantissa width. Bit MW-1 is the target position of the leading one.
- EW, 8, exponent width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- InValid  in  1  Sum/Exp are valid.
- InReady  out  1  block can accept a job. High only in IDLE with rst low.
- Sum  in  MW  unnormalized mantissa; leading one anywhere in [MW-1:0], or all zero.
- Exp  in  EW  exponent associated with Sum.
- OutValid  out  1  result valid; held until accepted.
- OutReady  in  1  downstream accepts result.
- Mout  out  MW  normalized mantissa, left-shifted by LZ, zeros filled at LSBs.
- Eout  out  EW  adjusted exponent.
- Zero  out  1  Sum was all zero.
- Underflow  out  1  LZ >= Exp (Sum nonzero).
- Shift  out  5  registered LZ of current/last job, for debug and the rounding stage.

## Operation
- States: IDLE, COARSE, FINE, DONE. Encoding is free.
- IDLE: InReady=1. On InValid:
  - Latch Sum into shift register M, Exp into E.
  - Compute LZ = number of leading zeros of Sum (0..MW). Latch it into Shift.
  - Sum==0: set Zero=1, M=0, E=0, Shift=MW; go to DONE.
  - Otherwise: go to COARSE.
- COARSE: M <= M << (4*Shift[4:2]), i.e. 0,4,…,24. Go to FINE.
- FINE: M <= M << Shift[1:0]; fill vacated LSBs with 0.
  - If E > Shift: E <= E - Shift, Underflow=0.
  - Else: E <= 0, Underflow=1. The mantissa is still fully shifted.
  - Go to DONE.
- DONE: OutValid=1; Mout=M, Eout=E, Zero, Underflow stable.
  - On OutReady: OutValid drops, go to IDLE.
  - No new job is accepted in the same cycle. InReady rises the cycle after.
- Invariant: for nonzero Sum, Mout[MW-1]=1 after FINE.
- Exponent subtraction is unsigned EW-bit, guarded by the compare, so it never wraps.
- Zero/Underflow are cleared when the next job is accepted.

## Timing
- Reset (rst high at an edge): state=IDLE, OutValid=0, Mout=0, Eout=0, Zero=0, Underflow=0, Shift=0. InReady=0 while rst is high.
- Reset mid-job (any state) aborts the job; no partial result is emitted.
- Accept edge k (InValid & InReady):
  - Nonzero Sum: COARSE in cycle k+1, FINE in k+2, OutValid=1 from cycle k+3.
  - Zero Sum: OutValid=1 from cycle k+1.
- Minimum job-to-job spacing: 4 cycles (nonzero, OutReady tied high), 2 cycles (zero).
- OutValid with OutReady low: all outputs hold indefinitely. InReady stays 0.
- Inputs are ignored outside IDLE. Sum/Exp changes while busy have no effect.
- All outputs are registered. InReady is decoded from the state register only and has no combinational path from InValid.

## Test plan
- Reset, then Sum=26'h2000000 (LZ=0), Exp=8'd100, OutReady=1 -> OutValid at k+3, Mout=26'h2000000, Eout=100, Shift=0, Zero=0, Underflow=0.
- Sum=26'h0000001 (LZ=25), Exp=8'd127 -> Mout=26'h2000000, Eout=102, Shift=25; the coarse step shifts by 24 and the fine step by 1.
- Sum=26'h0040000 (LZ=7), Exp=8'd5 -> Mout=26'h2000000, Eout=0, Underflow=1. Repeat with Exp=8'd7 -> Eout=0, Underflow=1. Repeat with Exp=8'd8 -> Eout=1, Underflow=0.
- Sum=0, Exp=8'd50 -> OutValid at k+1, Zero=1, Mout=0, Eout=0, Shift=26.
- OutReady held low for 10 cycles in DONE with InValid high and new Sum -> outputs stable, InReady=0, second job accepted only the cycle after OutReady pulses.
- rst asserted during FINE -> next cycle OutValid=0, all outputs 0. After rst deasserts, a fresh job completes normally with correct values.
